swb_issue: RTL and testbench
============================

Name: swb_issue

Overview:
- Issue-side credit manager for the store write buffer (SWB).
- Accepts upstream store requests and tags each one with a sequential SWB id (0..SWB_DEPTH-1, wrapping) that matches the SWB's in-order drain pointer.
- Forwards each tagged request downstream through a one-entry registered output stage.
- Issues only while it holds credit. The SWB returns one credit per drained entry via d_isu_crdt_rtn, so the number of outstanding tagged requests never exceeds SWB_DEPTH.

Parameters:
- SWB_DEPTH, 8, number of SWB entries and initial credit count; power of two, at least 2.
- ADDR_W, 32, request address width.
- DATA_W, 128, request payload width; must match the SWB entry data width.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- u_isu_valid  input  1  upstream request valid.
- u_isu_ready  output  1  upstream request accepted when valid & ready.
- u_isu_addr  input  ADDR_W  request address.
- u_isu_data  input  DATA_W  request store data.
- d_isu_valid  output  1  downstream request valid (registered).
- d_isu_ready  input  1  downstream request ready.
- d_isu_addr  output  ADDR_W  registered address.
- d_isu_data  output  DATA_W  registered data.
- d_isu_swb_id  output  $clog2(SWB_DEPTH)  SWB id assigned to this request.
- d_isu_crdt_rtn  input  1  one-cycle pulse from the SWB; returns one credit.
- crdt_cnt  output  $clog2(SWB_DEPTH)+1  current credit count.
- isu_idle  output  1  all credits home and output stage empty.
- crdt_err  output  1  sticky flag: credit returned while the counter is already at SWB_DEPTH.

Behaviour:
- Reset (rst=1 at posedge):
  - crdt_cnt = SWB_DEPTH; alloc id pointer = 0.
  - d_isu_valid = 0; d_isu_addr/data/swb_id = 0.
  - crdt_err = 0; isu_idle = 1; u_isu_ready = 1.
  - Reset mid-operation discards the pending output stage and restores full credit with no handshake; the SWB is reset in the same cycle.
- Handshakes:
  - u_hs = u_isu_valid & u_isu_ready.
  - d_hs = d_isu_valid & d_isu_ready.
- u_isu_ready = (crdt_cnt != 0) & (~d_isu_valid | d_isu_ready). It is combinational and must not depend on u_isu_valid.
- On u_hs:
  - Output stage loads addr, data and swb_id = alloc pointer; d_isu_valid = 1 next cycle (latency 1).
  - Alloc pointer increments modulo SWB_DEPTH: after SWB_DEPTH-1 comes 0.
  - crdt_cnt decrements.
- On d_hs without u_hs: d_isu_valid clears.
- On d_hs with u_hs in the same cycle: the stage reloads with the new request, d_isu_valid stays 1 (back-to-back, full throughput).
- While d_isu_valid=1 and d_isu_ready=0: addr, data and swb_id stay stable; no new accept.
- Credit arithmetic, per cycle:
  - u_hs only: -1.
  - crdt_rtn only: +1.
  - Both: unchanged.
- Credit is consumed at accept, not at the downstream handshake.
- Empty credit (crdt_cnt=0): u_isu_ready=0. A crdt_rtn in that cycle makes ready 1 in the next cycle; there is no same-cycle bypass.
- Overflow (crdt_rtn with crdt_cnt=SWB_DEPTH and no u_hs): crdt_cnt saturates at SWB_DEPTH and crdt_err sets and stays set until rst.
- isu_idle = (crdt_cnt == SWB_DEPTH) & ~d_isu_valid, combinational.
- Internal FSM (2 states, drives the output stage):
  - EMPTY -> FULL on u_hs.
  - FULL -> EMPTY on d_hs & ~u_hs.
  - FULL -> FULL on d_hs & u_hs, or on ~d_hs.
  - d_isu_valid = (state == FULL).

Test Plan:
- Reset then idle: assert rst 2 cycles -> crdt_cnt=8, isu_idle=1, d_isu_valid=0, u_isu_ready=1, crdt_err=0.
- Streaming issue: u_isu_valid=1 continuously, d_isu_ready=1, no credit return -> 8 accepts on consecutive cycles with swb_id 0..7; crdt_cnt reaches 0; u_isu_ready=0 from the 9th cycle; d_isu_valid drops one cycle after the last accept.
- Credit return and wrap: continue from the previous scenario, pulse crdt_rtn once -> crdt_cnt=1; next request accepted with swb_id=0 (wrap); crdt_cnt=0.
- Backpressure: one accept with addr=0x1000, data=0xA5..A5, then d_isu_ready=0 for 5 cycles -> outputs stable with swb_id=0; u_isu_ready=0 throughout; on release, d_hs occurs and the next request is accepted in the same cycle.
- Simultaneous accept and return: crdt_cnt=3, u_hs and crdt_rtn in the same cycle -> crdt_cnt stays 3.
- Overflow error and mid-op reset: pulse crdt_rtn at crdt_cnt=8 -> crdt_cnt stays 8, crdt_err=1 sticky. Then, with 4 outstanding and d_isu_valid=1, assert rst -> crdt_cnt=8, d_isu_valid=0, crdt_err=0, next swb_id=0.

Source files
------------

// File: rtl/swb_issue.sv
// Issue-side credit manager for the store write buffer: tags accepted stores
// with an in-order SWB id and forwards them through a one-entry output stage.
module swb_issue #(
  parameter int unsigned SWB_DEPTH = 8,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           u_isu_valid,
  output logic                           u_isu_ready,
  input  logic [ADDR_W-1:0]              u_isu_addr,
  input  logic [DATA_W-1:0]              u_isu_data,
  output logic                           d_isu_valid,
  input  logic                           d_isu_ready,
  output logic [ADDR_W-1:0]              d_isu_addr,
  output logic [DATA_W-1:0]              d_isu_data,
  output logic [$clog2(SWB_DEPTH)-1:0]   d_isu_swb_id,
  input  logic                           d_isu_crdt_rtn,
  output logic [$clog2(SWB_DEPTH):0]     crdt_cnt,
  output logic                           isu_idle,
  output logic                           crdt_err
);

  localparam int unsigned ID_W  = $clog2(SWB_DEPTH);
  localparam int unsigned CNT_W = ID_W + 1;
  localparam logic [CNT_W-1:0] FULL_CRDT = CNT_W'(SWB_DEPTH);

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                u_hs, d_hs;

  assign d_isu_valid  = (state_q == ST_FULL);
  assign d_isu_addr   = addr_q;
  assign d_isu_data   = data_q;
  assign d_isu_swb_id = id_q;
  assign crdt_cnt     = cnt_q;
  assign crdt_err     = err_q;
  assign u_isu_ready  = (cnt_q != '0) & (~d_isu_valid | d_isu_ready);
  assign isu_idle     = (cnt_q == FULL_CRDT) & ~d_isu_valid;
  assign u_hs         = u_isu_valid & u_isu_ready;
  assign d_hs         = d_isu_valid & d_isu_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      ST_EMPTY: if (u_hs)          state_d = ST_FULL;
      ST_FULL:  if (d_hs && !u_hs) state_d = ST_EMPTY;
      default:                     state_d = ST_EMPTY;
    endcase

    if (u_hs) begin
      addr_d = u_isu_addr;
      data_d = u_isu_data;
      id_d   = ptr_q;
      // Power-of-two depth: natural wrap of the pointer is the modulo.
      ptr_d  = ptr_q + ID_W'(1);
    end

    if (u_hs && !d_isu_crdt_rtn) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (d_isu_crdt_rtn && !u_hs) begin
      if (cnt_q == FULL_CRDT) err_d = 1'b1;
      else                    cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= FULL_CRDT;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_swb_issue.sv
// Directed bench for swb_issue: credit/handshake model plus a scoreboard of
// accepted requests compared against the downstream output stage.
module tb_swb_issue;

  logic         clk = 1'b0;
  logic         rst;
  logic         u_isu_valid;
  logic         u_isu_ready;
  logic [31:0]  u_isu_addr;
  logic [127:0] u_isu_data;
  logic         d_isu_valid;
  logic         d_isu_ready;
  logic [31:0]  d_isu_addr;
  logic [127:0] d_isu_data;
  logic [2:0]   d_isu_swb_id;
  logic         d_isu_crdt_rtn;
  logic [3:0]   crdt_cnt;
  logic         isu_idle;
  logic         crdt_err;

  swb_issue #(.SWB_DEPTH(8), .ADDR_W(32), .DATA_W(128)) dut (
    .clk            (clk),
    .rst            (rst),
    .u_isu_valid    (u_isu_valid),
    .u_isu_ready    (u_isu_ready),
    .u_isu_addr     (u_isu_addr),
    .u_isu_data     (u_isu_data),
    .d_isu_valid    (d_isu_valid),
    .d_isu_ready    (d_isu_ready),
    .d_isu_addr     (d_isu_addr),
    .d_isu_data     (d_isu_data),
    .d_isu_swb_id   (d_isu_swb_id),
    .d_isu_crdt_rtn (d_isu_crdt_rtn),
    .crdt_cnt       (crdt_cnt),
    .isu_idle       (isu_idle),
    .crdt_err       (crdt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  a;
    logic [127:0] d;
    logic [2:0]   id;
  } txn_t;

  txn_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  int         m_cnt;
  logic [2:0] m_id;
  logic       m_err;
  logic       m_dv;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u_isu_valid = 1'b0;
    d_isu_ready = 1'b0;
    d_isu_crdt_rtn = 1'b0;
    u_isu_addr = '0;
    u_isu_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_cnt = 8;
    m_id  = 3'd0;
    m_err = 1'b0;
    m_dv  = 1'b0;
    sb.delete();
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic tick(input logic v, input logic dr, input logic rtn,
                      input logic [31:0] a, input logic [127:0] dat);
    logic exp_rdy;
    logic uhs;
    txn_t t;
    u_isu_valid    = v;
    d_isu_ready    = dr;
    d_isu_crdt_rtn = rtn;
    u_isu_addr     = a;
    u_isu_data     = dat;
    @(negedge clk);
    exp_rdy = (m_cnt != 0) && (!m_dv || dr);
    check("u_isu_ready", 128'(u_isu_ready), 128'(exp_rdy));
    check("d_isu_valid", 128'(d_isu_valid), 128'(m_dv));
    check("crdt_cnt", 128'(crdt_cnt), 128'(m_cnt));
    check("isu_idle", 128'(isu_idle), 128'((m_cnt == 8) && !m_dv));
    check("crdt_err", 128'(crdt_err), 128'(m_err));
    if (m_dv) begin
      check("sb_nonempty", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        check("d_isu_addr", 128'(d_isu_addr), 128'(sb[0].a));
        check("d_isu_data", d_isu_data, sb[0].d);
        check("d_isu_swb_id", 128'(d_isu_swb_id), 128'(sb[0].id));
        if (dr) void'(sb.pop_front());
      end
    end
    uhs = v && exp_rdy;
    if (uhs) begin
      t.a = a; t.d = dat; t.id = m_id;
      sb.push_back(t);
      m_id = m_id + 3'd1;
    end
    if (uhs && !rtn) m_cnt = m_cnt - 1;
    else if (rtn && !uhs) begin
      if (m_cnt == 8) m_err = 1'b1;
      else            m_cnt = m_cnt + 1;
    end
    if (uhs)            m_dv = 1'b1;
    else if (m_dv && dr) m_dv = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    // Reset then idle
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0, '0);

    // Streaming: 8 accepts with ids 0..7, then credit exhausted
    for (int i = 0; i < 10; i++)
      tick(1'b1, 1'b1, 1'b0, 32'h100 + 32'(i), rnd128());
    check("stream_cnt_zero", 128'(crdt_cnt), 128'(0));

    // One credit back, next accept wraps to id 0
    tick(1'b0, 1'b1, 1'b1, 32'h0, '0);
    tick(1'b1, 1'b1, 1'b0, 32'h200, rnd128());
    tick(1'b0, 1'b1, 1'b0, 32'h0, '0);

    // Backpressure: held stage, then same-cycle drain and accept
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 32'h1000, {16{8'hA5}});
    for (int i = 0; i < 5; i++)
      tick(1'b1, 1'b0, 1'b0, 32'h1100 + 32'(i), rnd128());
    check("bp_held_id", 128'(d_isu_swb_id), 128'(0));
    tick(1'b1, 1'b1, 1'b0, 32'h2000, rnd128());
    tick(1'b0, 1'b1, 1'b0, 32'h0, '0);

    // Simultaneous accept and return at crdt_cnt=3
    for (int i = 0; i < 3; i++)
      tick(1'b1, 1'b1, 1'b0, 32'h3000 + 32'(i), rnd128());
    tick(1'b1, 1'b1, 1'b1, 32'h3100, rnd128());
    tick(1'b0, 1'b1, 1'b0, 32'h0, '0);

    // Overflow sets sticky error; mid-operation reset clears everything
    do_reset();
    tick(1'b0, 1'b1, 1'b1, 32'h0, '0);
    tick(1'b0, 1'b1, 1'b0, 32'h0, '0);
    for (int i = 0; i < 4; i++)
      tick(1'b1, 1'b1, 1'b0, 32'h4000 + 32'(i), rnd128());
    check("pre_rst_valid", 128'(d_isu_valid), 128'(1));
    check("pre_rst_cnt", 128'(crdt_cnt), 128'(4));
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 32'h5000, rnd128());
    tick(1'b0, 1'b1, 1'b0, 32'h0, '0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
